// File: rtl/data_bus_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package data_bus_pkg;
  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_FMT_W  = 3;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  // funct3 access formats
  localparam logic [2:0] FMT_BYTE  = 3'b000;
  localparam logic [2:0] FMT_HALF  = 3'b001;
  localparam logic [2:0] FMT_WORD  = 3'b010;
  localparam logic [2:0] FMT_BYTEU = 3'b100;
  localparam logic [2:0] FMT_HALFU = 3'b101;

  typedef struct packed {
    logic                  we;
    logic [BUS_ADDR_W-1:0] address;
    logic [BUS_DATA_W-1:0] write_data;
    logic [BUS_FMT_W-1:0]  format;
  } bus_req_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time is chosen.
module rr_arbiter2 import data_bus_pkg::*; (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);
  assign grant_valid = |req;
  assign grant_id    = (&req) ? ~last_grant : req[REQ_M1];
endmodule

// File: rtl/data_bus_arbiter.sv
// Shares one data-memory port between the core (m0) and a secondary master (m1),
// with round-robin grant, registered memory-side request and a no-response watchdog.
module data_bus_arbiter import data_bus_pkg::*; #(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int FMT_W   = BUS_FMT_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_write_enable,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_write_data,
  input  logic [FMT_W-1:0]  m0_format,
  output logic              m0_ready,
  output logic              m0_error,
  output logic [DATA_W-1:0] m0_read_data,
  input  logic              m1_req,
  input  logic              m1_write_enable,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_write_data,
  input  logic [FMT_W-1:0]  m1_format,
  output logic              m1_ready,
  output logic              m1_error,
  output logic [DATA_W-1:0] m1_read_data,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [FMT_W-1:0]  mem_format,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_read_data
);
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  logic [1:0]             req;
  bus_req_t [1:0]         mreq;
  logic                   grant_valid, grant_id;

  state_t                 state;
  bus_req_t               req_q;
  logic                   gid_q;
  logic                   last_grant;
  logic [WD_W-1:0]        wd;
  logic [1:0]             rdy_q, err_q;
  logic [1:0][DATA_W-1:0] rdata_q;
  logic                   timeout_hit;

  assign req          = {m1_req, m0_req};
  assign mreq[REQ_M0] = '{we: m0_write_enable, address: m0_address,
                          write_data: m0_write_data, format: m0_format};
  assign mreq[REQ_M1] = '{we: m1_write_enable, address: m1_address,
                          write_data: m1_write_data, format: m1_format};

  rr_arbiter2 u_rr (
    .req         (req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign timeout_hit = (TIMEOUT != 0) && (wd == WD_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_q      <= '0;
      gid_q      <= REQ_M0;
      last_grant <= REQ_M1;
      wd         <= '0;
      rdy_q      <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
    end else begin
      rdy_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      case (state)
        IDLE: if (grant_valid) begin
          req_q <= mreq[grant_id];
          gid_q <= grant_id;
          wd    <= '0;
          state <= BUSY;
        end
        BUSY: begin
          // mem_ready beats the watchdog when both land in the same cycle
          if (mem_ready) begin
            rdy_q[gid_q] <= 1'b1;
            if (!req_q.we) rdata_q[gid_q] <= mem_read_data;
            last_grant <= gid_q;
            wd         <= '0;
            state      <= IDLE;
          end else if (timeout_hit) begin
            err_q[gid_q] <= 1'b1;
            last_grant   <= gid_q;
            wd           <= '0;
            state        <= IDLE;
          end else if (TIMEOUT != 0) begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_read_enable  = (state == BUSY) & ~req_q.we;
  assign mem_write_enable = (state == BUSY) &  req_q.we;
  assign mem_address      = req_q.address;
  assign mem_write_data   = req_q.write_data;
  assign mem_format       = req_q.format;

  assign m0_ready     = rdy_q[REQ_M0];
  assign m0_error     = err_q[REQ_M0];
  assign m0_read_data = rdata_q[REQ_M0];
  assign m1_ready     = rdy_q[REQ_M1];
  assign m1_error     = err_q[REQ_M1];
  assign m1_read_data = rdata_q[REQ_M1];
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: directed transactions, memory responder, monitor.
module tb_data_bus_arbiter;
  import data_bus_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  fmt;
    bit          early;
  } tx_t;

  typedef struct {
    int          id;
    bit          err;
    logic [31:0] rdata;
    int          lat;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  fmt;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [1:0]       req_v = '0, we_v = '0;
  logic [1:0][31:0] addr_v = '0, wd_v = '0;
  logic [1:0][2:0]  fmt_v = '0;
  logic             mem_ready = 1'b0;
  logic [31:0]      mem_read_data = '0;

  logic        m0_ready, m0_error, m1_ready, m1_error;
  logic [31:0] m0_read_data, m1_read_data;
  logic        mem_read_enable, mem_write_enable;
  logic [31:0] mem_address, mem_write_data;
  logic [2:0]  mem_format;

  data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FMT_W(3), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .m0_req(req_v[0]), .m0_write_enable(we_v[0]), .m0_address(addr_v[0]),
    .m0_write_data(wd_v[0]), .m0_format(fmt_v[0]),
    .m0_ready(m0_ready), .m0_error(m0_error), .m0_read_data(m0_read_data),
    .m1_req(req_v[1]), .m1_write_enable(we_v[1]), .m1_address(addr_v[1]),
    .m1_write_data(wd_v[1]), .m1_format(fmt_v[1]),
    .m1_ready(m1_ready), .m1_error(m1_error), .m1_read_data(m1_read_data),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_format(mem_format),
    .mem_ready(mem_ready), .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  wire [1:0]       rdy = {m1_ready, m0_ready};
  wire [1:0]       err = {m1_error, m0_error};
  wire [1:0][31:0] rd  = {m1_read_data, m0_read_data};
  wire             strobe = mem_read_enable | mem_write_enable;
  wire [169:0]     all_out = {m0_ready, m0_error, m0_read_data, m1_ready, m1_error, m1_read_data,
                              mem_read_enable, mem_write_enable, mem_address, mem_write_data, mem_format};

  int   checks = 0, failures = 0;
  int   cyc = 0;
  tx_t  txq [2][$];
  exp_t exp_q [$];
  bit   [1:0] dropped = '0;
  int   rise_cyc [2];
  int   busy_start = 0, last_pulse_cyc = 0, rd_cycles = 0;
  int   mem_delay = 0;
  bit   mem_never = 1'b0;

  initial forever begin @(posedge clock); cyc++; end

  // memory responder: mem_ready in BUSY cycle mem_delay+1
  initial begin
    int bcnt;
    bcnt = 0;
    forever begin
      @(posedge clock); #1;
      if (strobe) bcnt++; else bcnt = 0;
      mem_ready = strobe && !mem_never && (bcnt == mem_delay + 1);
      mem_read_data = !mem_ready ? 32'h0 :
                      (mem_address == 32'h10) ? 32'hDEAD_BEEF : (mem_address ^ 32'hA5A5_0000);
    end
  end

  // requester driver: presents queue front, drops req on the ready/error it sees
  initial forever begin
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      logic nreq;
      if ((rdy[i] || err[i]) && txq[i].size() > 0) begin
        void'(txq[i].pop_front());
        dropped[i] = 1'b0;
      end
      if (txq[i].size() > 0 && txq[i][0].early && strobe && mem_address == txq[i][0].addr)
        dropped[i] = 1'b1;
      nreq = (txq[i].size() > 0) && !dropped[i];
      if (nreq && !req_v[i]) rise_cyc[i] = cyc;
      req_v[i] = nreq;
      if (txq[i].size() > 0) begin
        we_v[i] = txq[i][0].we; addr_v[i] = txq[i][0].addr;
        wd_v[i] = txq[i][0].wdata; fmt_v[i] = txq[i][0].fmt;
      end
    end
  end

  // monitor
  initial begin
    bit   in_busy;
    exp_t e;
    logic [67:0] snap;
    in_busy = 1'b0; snap = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin in_busy = 1'b0; continue; end
      checks++;
      if (mem_read_enable && mem_write_enable) begin
        failures++; $display("FAIL strobes_both rd=%b wr=%b required not both", mem_read_enable, mem_write_enable);
      end
      if (mem_read_enable) rd_cycles++;
      if (strobe && !in_busy) begin
        busy_start = cyc;
        snap = {mem_write_enable, mem_address, mem_write_data, mem_format};
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL unexpected_busy addr=%h required no access", mem_address);
        end else if (snap != {exp_q[0].we, exp_q[0].addr, exp_q[0].wdata, exp_q[0].fmt}) begin
          failures++;
          $display("FAIL grant_fields got we=%b a=%h d=%h f=%b required we=%b a=%h d=%h f=%b",
                   mem_write_enable, mem_address, mem_write_data, mem_format,
                   exp_q[0].we, exp_q[0].addr, exp_q[0].wdata, exp_q[0].fmt);
        end
      end else if (strobe) begin
        checks++;
        if ({mem_write_enable, mem_address, mem_write_data, mem_format} != snap) begin
          failures++; $display("FAIL busy_stable got %h required %h",
                               {mem_write_enable, mem_address, mem_write_data, mem_format}, snap);
        end
      end
      in_busy = strobe;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rdy[i] || err[i]) begin
          last_pulse_cyc = cyc;
          if (exp_q.size() == 0) begin
            failures++; $display("FAIL unexpected_pulse m%0d ready=%b error=%b required none", i, rdy[i], err[i]);
          end else begin
            e = exp_q.pop_front();
            if (e.id != i || err[i] != e.err || rdy[i] != !e.err || rd[i] != e.rdata ||
                cyc - busy_start != e.lat) begin
              failures++;
              $display("FAIL response got m%0d rdy=%b err=%b data=%h lat=%0d required m%0d err=%b data=%h lat=%0d",
                       i, rdy[i], err[i], rd[i], cyc - busy_start, e.id, e.err, e.rdata, e.lat);
            end
          end
        end else if (rd[i] != 32'h0) begin
          failures++; $display("FAIL idle_rdata m%0d got %h required 0", i, rd[i]);
        end
      end
    end
  end

  task automatic add(input int id, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] fmt, input bit early, input bit e_err,
                     input logic [31:0] e_rdata, input int lat);
    tx_t  t;
    exp_t e;
    t = '{we: we, addr: addr, wdata: wdata, fmt: fmt, early: early};
    e = '{id: id, err: e_err, rdata: e_rdata, lat: lat, we: we, addr: addr, wdata: wdata, fmt: fmt};
    txq[id].push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic flush();
    exp_q.delete(); txq[0].delete(); txq[1].delete(); dropped = '0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin @(posedge clock); n++; end
    checks++;
    if (exp_q.size() > 0) begin
      failures++; $display("FAIL %s_timeout pending=%0d required 0", name, exp_q.size());
      flush();
    end
    repeat (4) @(posedge clock);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (all_out != '0) begin
      failures++; $display("FAIL %s outputs=%h required 0", name, all_out);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // 1: reset held with both requesting; m0 wins first tie after release
    mem_delay = 0;
    add(0, 1'b0, 32'h100, 32'h0, FMT_WORD, 1'b0, 1'b0, 32'hA5A5_0100, 1);
    add(1, 1'b0, 32'h200, 32'h0, FMT_WORD, 1'b0, 1'b0, 32'hA5A5_0200, 1);
    repeat (4) @(negedge clock);
    check_zero("reset_hold");
    @(posedge clock); #2 reset = 1'b1;
    drain("t1");

    // 2: m0 word load, mem_ready on first BUSY cycle
    rd_cycles = 0;
    add(0, 1'b0, 32'h10, 32'h0, FMT_WORD, 1'b0, 1'b0, 32'hDEAD_BEEF, 1);
    drain("t2");
    checks++;
    if (rd_cycles != 1) begin failures++; $display("FAIL t2_rd_cycles got %0d required 1", rd_cycles); end
    checks++;
    if (last_pulse_cyc - rise_cyc[0] != 2) begin
      failures++; $display("FAIL t2_latency got %0d required 2", last_pulse_cyc - rise_cyc[0]);
    end

    // 4: m1 byte store, req dropped after first BUSY cycle
    mem_delay = 2;
    add(1, 1'b1, 32'hFF0, 32'h1234_5678, FMT_BYTE, 1'b1, 1'b0, 32'h0, 3);
    drain("t4");

    // 3: both requesting for six transactions, alternating grants
    for (int k = 0; k < 3; k++) begin
      add(0, 1'b0, 32'h100, 32'h0, FMT_WORD, 1'b0, 1'b0, 32'hA5A5_0100, 3);
      add(1, 1'b0, 32'h200, 32'h0, FMT_HALFU, 1'b0, 1'b0, 32'hA5A5_0200, 3);
    end
    drain("t3");

    // 5: watchdog abort, normal m1 afterwards, then mem_ready on the 16th cycle
    mem_never = 1'b1;
    add(0, 1'b0, 32'h300, 32'h0, FMT_WORD, 1'b0, 1'b1, 32'h0, 16);
    drain("t5a");
    mem_never = 1'b0; mem_delay = 0;
    add(1, 1'b0, 32'h400, 32'h0, FMT_BYTEU, 1'b0, 1'b0, 32'hA5A5_0400, 1);
    drain("t5b");
    mem_delay = 15;
    add(0, 1'b0, 32'h500, 32'h0, FMT_HALF, 1'b0, 1'b0, 32'hA5A5_0500, 16);
    drain("t5c");

    // 6: reset mid-BUSY while mem_ready is high
    mem_delay = 1;
    add(1, 1'b0, 32'h600, 32'h0, FMT_WORD, 1'b0, 1'b0, 32'hA5A5_0600, 2);
    begin
      int n;
      n = 0;
      while (!strobe && n < 20) begin @(negedge clock); n++; end
      checks++;
      if (!strobe) begin failures++; $display("FAIL t6_busy strobe=%b required 1", strobe); end
    end
    @(posedge clock); #2;
    reset = 1'b0;
    #1 check_zero("t6_async_reset");
    flush();
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    repeat (20) @(posedge clock);
    @(negedge clock);
    check_zero("t6_after_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
